// File: rtl/pix_loader_pkg.sv
// Shared types and widths for the pixel nibble loader and its phase counter.
package pix_loader_pkg;

    localparam int NIB_W   = 4;
    localparam int PHASE_W = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pix_nibble_loader_phase_ctr.sv
// Pixel phase counter: wraps every 4 enabled cycles and flags phase 0, the
// cycle on which the shift register takes a parallel load.
module nibble_phase_ctr
    import pix_loader_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               clr_i,
    input  logic               en_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic               tc_o
);

    logic [PHASE_W-1:0] phase_q;
    logic [PHASE_W-1:0] phase_d;

    always_comb begin
        phase_d = phase_q;
        if (clr_i) begin
            phase_d = '0;
        end else if (en_i) begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o = phase_q;
    assign tc_o    = (phase_q == '0);

endmodule

// File: rtl/pix_nibble_loader.sv
// Feeds a 4-bit parallel-load video shift register: fetches one nibble ahead
// from ROM per line and strobes a load every fourth active pixel.
module pix_nibble_loader
    import pix_loader_pkg::*;
#(
    parameter int   ADDR_W           = 10,
    parameter int   NIBBLES_PER_LINE = 64,
    parameter logic SER_FILL         = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               pix_en_i,
    input  logic               active_i,
    input  logic               line_start_i,
    output logic               rd_req_o,
    output logic [ADDR_W-1:0]  rd_addr_o,
    input  logic               rd_ack_i,
    input  logic [NIB_W-1:0]   rd_data_i,
    output logic               mode_o,
    output logic               shift_ce_o,
    output logic               a_o,
    output logic               b_o,
    output logic               c_o,
    output logic               d_o,
    output logic               ser_o,
    output logic               underrun_o,
    output logic               line_done_o,
    output logic [1:0]         dbg_state_o,
    output logic [PHASE_W-1:0] dbg_phase_o
);

    localparam int CNT_W = $clog2(NIBBLES_PER_LINE + 1);
    localparam int AW1   = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(NIBBLES_PER_LINE);
    localparam logic [AW1-1:0]   ADDR_SAT = AW1'(NIBBLES_PER_LINE);

    fetch_state_t     state_q;
    logic [AW1-1:0]   addr_q;
    logic [AW1-1:0]   addr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [NIB_W-1:0] buf_q;
    logic             valid_q;
    logic             valid_d;
    logic             rd_req_q;
    logic             mode_q;
    logic             shift_ce_q;
    logic [NIB_W-1:0] nib_q;
    logic             underrun_q;
    logic             line_done_q;

    logic             pix_qual;
    logic             phase_tc;
    logic             load;
    logic             ack_take;

    // ROM handshake: rd_req_o rises registered and holds with a stable address
    // until the first cycle where rd_ack_i is also high; that cycle captures
    // rd_data_i and drops the request. Acks seen with no request are ignored.
    assign pix_qual = pix_en_i & active_i & ~line_start_i;
    assign load     = pix_qual & phase_tc;
    assign ack_take = (state_q == REQ) & rd_req_q & rd_ack_i;

    assign addr_d = (addr_q == ADDR_SAT) ? addr_q : addr_q + 1'b1;
    assign cnt_d  = (cnt_q == LINE_CNT) ? cnt_q : cnt_q + 1'b1;

    // The fetch path only ever fills an empty buffer, so the two writes never collide.
    always_comb begin
        valid_d = valid_q;
        if (load && valid_q) begin
            valid_d = 1'b0;
        end
        if (ack_take) begin
            valid_d = 1'b1;
        end
    end

    nibble_phase_ctr u_phase (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (line_start_i),
        .en_i    (pix_qual),
        .phase_o (dbg_phase_o),
        .tc_o    (phase_tc)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            valid_q     <= 1'b0;
            rd_req_q    <= 1'b0;
            mode_q      <= 1'b0;
            shift_ce_q  <= 1'b0;
            nib_q       <= '0;
            underrun_q  <= 1'b0;
            line_done_q <= 1'b0;
        end else if (line_start_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            valid_q     <= 1'b0;
            rd_req_q    <= 1'b0;
            mode_q      <= 1'b0;
            shift_ce_q  <= 1'b0;
            underrun_q  <= 1'b0;
            line_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cnt_q == LINE_CNT) begin
                        state_q     <= DONE;
                        line_done_q <= 1'b1;
                    end else if (!valid_q) begin
                        state_q  <= REQ;
                        rd_req_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (ack_take) begin
                        buf_q    <= rd_data_i;
                        addr_q   <= addr_d;
                        cnt_q    <= cnt_d;
                        rd_req_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                DONE: begin
                    rd_req_q    <= 1'b0;
                    line_done_q <= 1'b1;
                end
                default: begin
                    state_q  <= IDLE;
                    rd_req_q <= 1'b0;
                end
            endcase

            valid_q    <= valid_d;
            mode_q     <= load;
            shift_ce_q <= pix_qual;
            if (load) begin
                if (valid_q) begin
                    nib_q <= buf_q;
                end else begin
                    nib_q      <= '0;
                    underrun_q <= 1'b1;
                end
            end
        end
    end

    assign rd_req_o    = rd_req_q;
    assign rd_addr_o   = addr_q[ADDR_W-1:0];
    assign mode_o      = mode_q;
    assign shift_ce_o  = shift_ce_q;
    assign a_o         = nib_q[3];
    assign b_o         = nib_q[2];
    assign c_o         = nib_q[1];
    assign d_o         = nib_q[0];
    assign ser_o       = SER_FILL;
    assign underrun_o  = underrun_q;
    assign line_done_o = line_done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pix_nibble_loader.sv
// Bench for pix_nibble_loader: queue-based pixel/fetch model plus directed line scenarios.
module tb_pix_nibble_loader;
    import pix_loader_pkg::*;

    localparam int ADDR_W = 4;
    localparam int NPL    = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;
    logic active = 1'b0;
    logic line_start = 1'b0;

    logic rom_en = 1'b0;
    logic rom_ack = 1'b0;
    logic [3:0] rom_data = 4'h0;
    logic man_ack = 1'b0;
    logic [3:0] man_data = 4'h0;
    logic rd_ack_w;
    logic [3:0] rd_data_w;

    logic rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic mode, shift_ce, a, b, c, d, ser, underrun, line_done;
    logic [1:0] dbg_state;
    logic [PHASE_W-1:0] dbg_phase;

    int total = 0;
    int bad = 0;

    assign rd_ack_w  = rom_ack | man_ack;
    assign rd_data_w = man_ack ? man_data : rom_data;

    pix_nibble_loader #(
        .ADDR_W           (ADDR_W),
        .NIBBLES_PER_LINE (NPL),
        .SER_FILL         (1'b0)
    ) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .pix_en_i     (pix_en),
        .active_i     (active),
        .line_start_i (line_start),
        .rd_req_o     (rd_req),
        .rd_addr_o    (rd_addr),
        .rd_ack_i     (rd_ack_w),
        .rd_data_i    (rd_data_w),
        .mode_o       (mode),
        .shift_ce_o   (shift_ce),
        .a_o          (a),
        .b_o          (b),
        .c_o          (c),
        .d_o          (d),
        .ser_o        (ser),
        .underrun_o   (underrun),
        .line_done_o  (line_done),
        .dbg_state_o  (dbg_state),
        .dbg_phase_o  (dbg_phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // ROM responder: acks on the (rom_lat+1)-th cycle of a request.
    logic [3:0] rom [0:15];
    int rom_lat = 0;
    int wait_cnt = 0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt = 0;
            rom_ack  = 1'b0;
        end else if (rom_en) begin
            rom_ack = 1'b0;
            if (rd_req) begin
                if (wait_cnt >= rom_lat) begin
                    rom_ack  = 1'b1;
                    rom_data = rom[rd_addr];
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end else begin
            rom_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Behavioural model: exp_q is the one-ahead nibble buffer.
    logic [3:0] exp_q[$];
    int m_phase = 0;
    int m_fetched = 0;
    logic e_mode = 1'b0;
    logic e_ce = 1'b0;
    logic e_und = 1'b0;
    logic e_done = 1'b0;
    logic [3:0] e_nib = 4'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q.delete();
            m_phase = 0; m_fetched = 0;
            e_mode = 1'b0; e_ce = 1'b0; e_und = 1'b0; e_done = 1'b0; e_nib = 4'h0;
        end else if (line_start) begin
            exp_q.delete();
            m_phase = 0; m_fetched = 0;
            e_mode = 1'b0; e_ce = 1'b0; e_und = 1'b0; e_done = 1'b0;
        end else begin
            if (pix_en && active) begin
                e_ce   = 1'b1;
                e_mode = (m_phase == 0);
                if (m_phase == 0) begin
                    if (exp_q.size() > 0) begin
                        e_nib = exp_q.pop_front();
                    end else begin
                        e_nib = 4'h0;
                        e_und = 1'b1;
                    end
                end
                m_phase = (m_phase + 1) % 4;
            end else begin
                e_ce   = 1'b0;
                e_mode = 1'b0;
            end
            if (m_fetched == NPL) e_done = 1'b1;
            if (rd_ack_w && rd_req) begin
                exp_q.push_back(rd_data_w);
                m_fetched++;
            end
        end
    end

    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("mode", mode, e_mode);
            check("shift_ce", shift_ce, e_ce);
            check("nibble", {a, b, c, d}, e_nib);
            check("underrun", underrun, e_und);
            check("line_done", line_done, e_done);
            check("ser", ser, 1'b0);
            if (rd_req) begin
                check("req_addr", rd_addr, m_fetched[ADDR_W-1:0]);
                check("req_buf_empty", exp_q.size(), 0);
                check("req_in_line", (m_fetched < NPL), 1'b1);
            end
        end
    end

    task automatic pulse_line_start();
        @(negedge clk);
        line_start = 1'b1;
        @(negedge clk);
        line_start = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (!rd_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_req_seen"}, rd_req, 1'b1);
    endtask

    int loads;
    int req_cnt;
    logic prev_req;

    initial begin
        rom[0] = 4'hA; rom[1] = 4'h5; rom[2] = 4'h3; rom[3] = 4'hC;
        for (int i = 4; i < 16; i++) rom[i] = 4'(i);

        // Power-on reset values
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req", rd_req, 1'b0);
        check("rst_addr", rd_addr, 0);
        check("rst_mode", mode, 1'b0);
        check("rst_ce", shift_ce, 1'b0);
        check("rst_nib", {a, b, c, d}, 4'h0);
        check("rst_und", underrun, 1'b0);
        check("rst_done", line_done, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        rom_en = 1'b1;
        rom_lat = 0;
        pix_en = 1'b1;

        // 1-cycle ROM, pixel every cycle
        pulse_line_start();
        repeat (4) @(negedge clk);
        active = 1'b1;
        @(negedge clk);
        check("t2_load1_mode", mode, 1'b1);
        check("t2_load1_nib", {a, b, c, d}, 4'hA);
        repeat (4) @(negedge clk);
        check("t2_load2_mode", mode, 1'b1);
        check("t2_load2_nib", {a, b, c, d}, 4'h5);
        check("t2_und", underrun, 1'b0);
        active = 1'b0;

        // Async reset while a request is outstanding
        rom_lat = 0;
        pulse_line_start();
        repeat (4) @(negedge clk);
        rom_lat = 50;
        active = 1'b1;
        @(negedge clk);
        active = 1'b0;
        wait_req("t1");
        check("t1_addr_before", rd_addr, 1);
        check("t1_nib_before", {a, b, c, d}, 4'hA);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_req_async", rd_req, 1'b0);
        check("t1_addr_async", rd_addr, 0);
        check("t1_nib_async", {a, b, c, d}, 4'h0);
        check("t1_mode_async", mode, 1'b0);
        check("t1_ce_async", shift_ce, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        rom_lat = 0;
        wait_req("t1_post");
        check("t1_addr_post", rd_addr, 0);

        // Slow ROM causes an underrun on the second load
        rom_lat = 6;
        pulse_line_start();
        repeat (12) @(negedge clk);
        active = 1'b1;
        @(negedge clk);
        check("t3_load1_nib", {a, b, c, d}, 4'hA);
        check("t3_load1_und", underrun, 1'b0);
        repeat (4) @(negedge clk);
        check("t3_load2_mode", mode, 1'b1);
        check("t3_load2_nib", {a, b, c, d}, 4'h0);
        check("t3_load2_und", underrun, 1'b1);
        active = 1'b0;
        pulse_line_start();
        check("t3_und_cleared", underrun, 1'b0);

        // Full line: exactly NPL requests then DONE
        rom_lat = 0;
        active = 1'b1;
        pulse_line_start();
        req_cnt = 0;
        prev_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rd_req && !prev_req) begin
                check("t4_addr_seq", rd_addr, req_cnt);
                req_cnt++;
            end
            prev_req = rd_req;
            @(negedge clk);
        end
        check("t4_req_count", req_cnt, NPL);
        check("t4_line_done", line_done, 1'b1);
        check("t4_state_done", dbg_state, 2'd2);
        check("t4_no_req", rd_req, 1'b0);
        active = 1'b0;

        // LINE_START coincident with ACK
        rom_en = 1'b0;
        pulse_line_start();
        wait_req("t5");
        man_ack = 1'b1;
        man_data = 4'hF;
        line_start = 1'b1;
        active = 1'b1;
        @(negedge clk);
        man_ack = 1'b0;
        line_start = 1'b0;
        active = 1'b0;
        check("t5_mode", mode, 1'b0);
        check("t5_ce", shift_ce, 1'b0);
        check("t5_phase", dbg_phase, 0);
        check("t5_state", dbg_state, 2'd0);
        rom_en = 1'b1;
        wait_req("t5_next");
        check("t5_next_addr", rd_addr, 0);
        repeat (3) @(negedge clk);
        active = 1'b1;
        @(negedge clk);
        check("t5_load_mode", mode, 1'b1);
        check("t5_load_nib", {a, b, c, d}, 4'hA);

        // Blank at phase 2 freezes the phase
        @(negedge clk);
        active = 1'b0;
        check("t6_phase_frozen", dbg_phase, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t6_ce_blank", shift_ce, 1'b0);
        end
        active = 1'b1;
        loads = 0;
        @(negedge clk);
        check("t6_ph2_mode", mode, 1'b0);
        check("t6_ph2_ce", shift_ce, 1'b1);
        @(negedge clk);
        check("t6_ph3_mode", mode, 1'b0);
        @(negedge clk);
        check("t6_load_mode", mode, 1'b1);
        check("t6_load_nib", {a, b, c, d}, 4'h5);
        active = 1'b0;
        repeat (2) @(negedge clk);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
